// File: rtl/sort_8x8b_unpack_stream.sv
// rtl/sort_8x8b_unpack_stream.sv - serialises a packed sorted word one element per cycle
// Flags words that are not ascending by lane and keeps a saturating count of them.
module sort_8x8b_unpack_stream #(
  parameter int N_ELEM = 8,
  parameter int W      = 8,
  parameter int CNT_W  = 8,
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_ELEM*W-1:0]   in_data,
  input  logic                  in_desc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  sort_err,
  output logic [CNT_W-1:0]      err_count
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t              state, state_next;
  logic [N_ELEM*W-1:0] word_q;
  logic                desc_q;
  logic [IDX_W-1:0]    idx_q;
  logic                sort_err_q;
  logic [CNT_W-1:0]    err_count_q;

  logic                in_bad;
  logic                is_last;
  logic                accept;
  logic                advance;
  logic [IDX_W-1:0]    lane_sel;
  logic [W-1:0]        lanes [N_ELEM];

  always_comb begin
    in_bad = 1'b0;
    for (int k = 0; k < N_ELEM - 1; k++) begin
      if (in_data[k*W +: W] > in_data[(k+1)*W +: W]) in_bad = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < N_ELEM; k++) lanes[k] = word_q[k*W +: W];
  end

  assign is_last   = (idx_q == LAST_IDX);
  assign out_valid = (state == STREAM);
  assign out_last  = out_valid & is_last;
  assign advance   = out_valid & out_ready;
  // Ready may rise on the final element's handshake so consecutive words stream without a bubble.
  assign in_ready  = !rst & ((state == IDLE) | (out_last & out_ready));
  assign accept    = in_valid & in_ready;
  assign lane_sel  = desc_q ? (LAST_IDX - idx_q) : idx_q;
  assign out_data  = lanes[lane_sel];
  assign out_idx   = idx_q;
  assign sort_err  = sort_err_q;
  assign err_count = err_count_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = STREAM;
      STREAM:  if (advance && is_last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_q      <= '0;
      desc_q      <= 1'b0;
      idx_q       <= '0;
      sort_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word_q     <= in_data;
        desc_q     <= in_desc;
        idx_q      <= '0;
        sort_err_q <= in_bad;
        if (in_bad && !(&err_count_q)) err_count_q <= err_count_q + 1'b1;
      end else if (advance && !is_last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule
